// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin arbiter sharing one sync_fifo write port among
//               NUM_REQUESTERS valid/ready producers. The winning word is
//               registered into a single output stage that drives the FIFO
//               enqueue. Grants are gated on FIFO full/almost_full, and a
//               flush request is sequenced as: stop granting, drain the
//               output stage, then pulse the FIFO flush for one cycle.
//               The FIFO must be built with ALMOST_FULL_THRESHOLD = SIZE-1.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int WIDTH          = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQUESTERS-1:0]       req_valid,
    input  logic [NUM_REQUESTERS*WIDTH-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]       req_ready,
    input  logic                            flush_req,
    output logic                            flush_done,
    input  logic                            fifo_full,
    input  logic                            fifo_almost_full,
    output logic                            fifo_enqueue_en,
    output logic [WIDTH-1:0]                fifo_value,
    output logic                            fifo_flush_en
);

    localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_REQUESTERS - 1);

    logic [1:0]       r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_found;
    logic [PTR_W-1:0] w_winner;
    logic             w_space_ok;
    logic             w_grant_en;
    logic [WIDTH-1:0] w_win_data;

    // Conservative space check: the FIFO must hold both the word already in
    // the output stage and the one we are about to grant. Dequeues are not
    // credited, so this never over-commits.
    assign w_space_ok = !fifo_full && !(r_out_valid && fifo_almost_full);

    // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
    always_comb begin : p_arb
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQUESTERS) begin
                v_idx = v_idx - NUM_REQUESTERS;
            end
            if (!w_found && req_valid[v_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = v_idx[PTR_W-1:0];
            end
        end
    end

    // A grant needs RUN, no flush request this cycle, FIFO room and a valid
    // requester. Reset closes the gate so no word is accepted and then lost.
    assign w_grant_en = !reset && (r_state == S_RUN) && !flush_req
                        && w_space_ok && w_found;

    assign w_win_data = req_data[int'(w_winner)*WIDTH +: WIDTH];

    // One-hot grant to the winner; zero when no grant is issued.
    assign req_ready = w_grant_en ? (NUM_REQUESTERS'(1) << w_winner)
                                  : '0;

    // Output stage drives the FIFO directly; everything reads as 0 in reset.
    assign fifo_enqueue_en = r_out_valid && !reset;
    assign fifo_value      = reset ? '0 : r_out_data;
    assign fifo_flush_en   = (r_state == S_FLUSH) && !reset;
    assign flush_done      = fifo_flush_en;

    // Flush sequencer, round-robin pointer and output stage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_grant_en;
            if (w_grant_en) begin
                r_out_data <= w_win_data;
                r_rr_ptr   <= (w_winner == c_last_idx) ? '0
                                                       : w_winner + 1'b1;
            end
            case (r_state)
                S_RUN: begin
                    if (flush_req) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The stage empties in one cycle since no grants are made.
                    if (!r_out_valid) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_state  <= S_RUN;
                    r_rr_ptr <= '0;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (reset)
        !(fifo_enqueue_en && fifo_full));
    a_no_enq_with_flush: assert property (@(posedge clk) disable iff (reset)
        !(fifo_enqueue_en && fifo_flush_en));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed, table-driven bench for fifo_write_arbiter with a
//               small FIFO occupancy model (SIZE=8, almost_full at SIZE-1),
//               plus hand sequences for reset and a 2-requester instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int N    = 4;
    localparam int W    = 64;
    localparam int SIZE = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             flush_req;
    logic             flush_done;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             fifo_enqueue_en;
    logic [W-1:0]     fifo_value;
    logic             fifo_flush_en;
    logic             deq;
    int               fifo_count = 0;

    // second instance: 2 requesters, 8-bit words, FIFO never full
    logic [1:0]  r2_valid;
    logic [15:0] r2_data;
    logic [1:0]  r2_ready;
    logic        r2_flush_req;
    logic        r2_flush_done;
    logic        r2_full;
    logic        r2_afull;
    logic        r2_enq;
    logic [7:0]  r2_value;
    logic        r2_flush_en;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_write_arbiter #(.NUM_REQUESTERS(N), .WIDTH(W)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .flush_req        (flush_req),
        .flush_done       (flush_done),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_enqueue_en  (fifo_enqueue_en),
        .fifo_value       (fifo_value),
        .fifo_flush_en    (fifo_flush_en)
    );

    fifo_write_arbiter #(.NUM_REQUESTERS(2), .WIDTH(8)) u_dut2 (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (r2_valid),
        .req_data         (r2_data),
        .req_ready        (r2_ready),
        .flush_req        (r2_flush_req),
        .flush_done       (r2_flush_done),
        .fifo_full        (r2_full),
        .fifo_almost_full (r2_afull),
        .fifo_enqueue_en  (r2_enq),
        .fifo_value       (r2_value),
        .fifo_flush_en    (r2_flush_en)
    );

    // FIFO occupancy model (shares the arbiter reset)
    assign fifo_full        = (fifo_count >= SIZE);
    assign fifo_almost_full = (fifo_count >= SIZE - 1);
    always @(posedge clk) begin
        if (reset)              fifo_count <= 0;
        else if (fifo_flush_en) fifo_count <= 0;
        else fifo_count <= fifo_count + (fifo_enqueue_en ? 1 : 0)
                           - ((deq && fifo_count > 0) ? 1 : 0);
    end

    function automatic logic [W-1:0] dword(int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    typedef struct {
        logic [N-1:0] valid;
        logic         flush;
        logic         deq;
        logic [N-1:0] ready;
        logic         enq;
        int           val_idx;
        logic         fl;
    } vec_t;

    function automatic vec_t mk(logic [N-1:0] v, logic f, logic d,
                                logic [N-1:0] r, logic e, int vi, logic fl);
        vec_t t;
        t.valid = v; t.flush = f; t.deq = d;
        t.ready = r; t.enq = e; t.val_idx = vi; t.fl = fl;
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[28];

    initial begin
        logic [7:0] exp2_prev;
        logic       have_prev;
        // rows 1..10: all valid, FIFO fills to 8 entries
        vecs[0]  = mk(4'b1111, 0, 0, 4'b0001, 0, 0, 0);
        vecs[1]  = mk(4'b1111, 0, 0, 4'b0010, 1, 0, 0);
        vecs[2]  = mk(4'b1111, 0, 0, 4'b0100, 1, 1, 0);
        vecs[3]  = mk(4'b1111, 0, 0, 4'b1000, 1, 2, 0);
        vecs[4]  = mk(4'b1111, 0, 0, 4'b0001, 1, 3, 0);
        vecs[5]  = mk(4'b1111, 0, 0, 4'b0010, 1, 0, 0);
        vecs[6]  = mk(4'b1111, 0, 0, 4'b0100, 1, 1, 0);
        vecs[7]  = mk(4'b1111, 0, 0, 4'b1000, 1, 2, 0);
        vecs[8]  = mk(4'b1111, 0, 0, 4'b0000, 1, 3, 0);
        vecs[9]  = mk(4'b1111, 0, 0, 4'b0000, 0, 0, 0);
        // one dequeue -> exactly one more grant
        vecs[10] = mk(4'b1111, 0, 1, 4'b0000, 0, 0, 0);
        vecs[11] = mk(4'b1111, 0, 0, 4'b0001, 0, 0, 0);
        vecs[12] = mk(4'b1111, 0, 0, 4'b0000, 1, 0, 0);
        vecs[13] = mk(4'b1111, 0, 0, 4'b0000, 0, 0, 0);
        // flush while full: RUN -> DRAIN -> FLUSH -> RUN, pointer back to 0
        vecs[14] = mk(4'b1111, 1, 0, 4'b0000, 0, 0, 0);
        vecs[15] = mk(4'b1111, 0, 0, 4'b0000, 0, 0, 0);
        vecs[16] = mk(4'b1111, 0, 0, 4'b0000, 0, 0, 1);
        vecs[17] = mk(4'b1111, 0, 0, 4'b0001, 0, 0, 0);
        // flush where a grant would occur; flush_req ignored in DRAIN/FLUSH
        vecs[18] = mk(4'b1111, 1, 0, 4'b0000, 1, 0, 0);
        vecs[19] = mk(4'b1111, 1, 0, 4'b0000, 0, 0, 0);
        vecs[20] = mk(4'b1111, 1, 0, 4'b0000, 0, 0, 1);
        vecs[21] = mk(4'b1111, 0, 0, 4'b0001, 0, 0, 0);
        // only requesters 1 and 3 valid, pointer at 2 after the first grant
        vecs[22] = mk(4'b0010, 0, 0, 4'b0010, 1, 0, 0);
        vecs[23] = mk(4'b1010, 0, 0, 4'b1000, 1, 1, 0);
        vecs[24] = mk(4'b1010, 0, 0, 4'b0010, 1, 3, 0);
        vecs[25] = mk(4'b1010, 0, 0, 4'b1000, 1, 1, 0);
        vecs[26] = mk(4'b1010, 0, 0, 4'b0010, 1, 3, 0);
        vecs[27] = mk(4'b0000, 0, 0, 4'b0000, 1, 1, 0);

        for (int i = 0; i < N; i++) req_data[i*W +: W] = dword(i);
        r2_data      = {8'h51, 8'h50};
        r2_valid     = 2'b00;
        r2_flush_req = 1'b0;
        r2_full      = 1'b0;
        r2_afull     = 1'b0;
        deq          = 1'b0;
        flush_req    = 1'b0;
        req_valid    = 4'b1111;
        reset        = 1'b1;

        // reset state: outputs 0 even with requesters valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 64'(req_ready), 64'h0);
        chk("reset enq", 64'(fifo_enqueue_en), 64'h0);
        chk("reset value", fifo_value, 64'h0);
        chk("reset flush_en", 64'(fifo_flush_en), 64'h0);
        chk("reset flush_done", 64'(flush_done), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            req_valid = vecs[i].valid;
            flush_req = vecs[i].flush;
            deq       = vecs[i].deq;
            @(negedge clk);
            chk($sformatf("row%0d ready", i + 1), 64'(req_ready), 64'(vecs[i].ready));
            chk($sformatf("row%0d enq", i + 1), 64'(fifo_enqueue_en), 64'(vecs[i].enq));
            if (vecs[i].enq)
                chk($sformatf("row%0d value", i + 1), fifo_value, dword(vecs[i].val_idx));
            chk($sformatf("row%0d flush_en", i + 1), 64'(fifo_flush_en), 64'(vecs[i].fl));
            chk($sformatf("row%0d flush_done", i + 1), 64'(flush_done), 64'(vecs[i].fl));
            if (fifo_enqueue_en && fifo_full)
                chk($sformatf("row%0d enq while full", i + 1), 64'h1, 64'h0);
            @(posedge clk); #1;
        end

        // reset while the output stage holds a word
        req_valid = 4'b1111; flush_req = 1'b0; deq = 1'b0;
        @(negedge clk);
        chk("pre-reset grant", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("in-reset ready", 64'(req_ready), 64'h0);
        chk("in-reset enq", 64'(fifo_enqueue_en), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("post-reset enq", 64'(fifo_enqueue_en), 64'h0);
        chk("post-reset grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("post-reset enq word", 64'(fifo_enqueue_en), 64'h1);
        chk("post-reset value", fifo_value, dword(1));
        @(posedge clk); #1;

        // two requesters: 0 valid on alternate cycles, 1 always valid
        have_prev = 1'b0;
        exp2_prev = 8'h00;
        for (int c = 0; c < 8; c++) begin
            logic [1:0] exp_r;
            r2_valid = {1'b1, (c % 2 == 1)};
            exp_r    = (c % 2 == 1) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("n2 c%0d ready", c), 64'(r2_ready), 64'(exp_r));
            chk($sformatf("n2 c%0d enq", c), 64'(r2_enq), 64'(have_prev));
            if (have_prev)
                chk($sformatf("n2 c%0d value", c), 64'(r2_value), 64'(exp2_prev));
            exp2_prev = (c % 2 == 1) ? 8'h50 : 8'h51;
            have_prev = 1'b1;
            @(posedge clk); #1;
        end
        r2_valid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
